// File: rtl/serial_adder_n_if.sv
// Handshake and result bundle for serial_adder_n.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             ovf;
    logic             sum_bit;
    logic             sum_bit_valid;

    modport master (
        output start,
        output a,
        output b,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy,
        input  done,
        input  sum,
        input  carry_out,
        input  ovf,
        input  sum_bit,
        input  sum_bit_valid
    );

    modport slave (
        input  start,
        input  a,
        input  b,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy,
        output done,
        output sum,
        output carry_out,
        output ovf,
        output sum_bit,
        output sum_bit_valid
    );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial ripple adder, one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub input (A-B via ~B and carry-in 1).
module serial_adder_n #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clock,
    input logic            clear,
    serial_adder_n_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             busy_q;
    logic             done_q;
    logic             sbit_q;
    logic             sbv_q;
    logic             co_q;
    logic             ovf_q;

    logic             sub_c;
    logic             s_c;
    logic             cout_c;
    logic             last_c;
    logic             load_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_c = bus.sub;
`else
    assign sub_c = 1'b0;
`endif

    // One full-adder slice over the current LSBs
    assign s_c    = a_q[0] ^ b_q[0] ^ c_q;
    assign cout_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    assign last_c = (cnt_q == CW'(WIDTH - 1));
    assign load_c = (state_q == IDLE) && bus.start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A doubles as the result register: sum bits enter at its MSB as operand bits leave
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sbit_q  <= 1'b0;
            sbv_q   <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
            sbv_q   <= 1'b0;
            if (load_c) begin
                a_q   <= bus.a;
                b_q   <= sub_c ? ~bus.b : bus.b;
                c_q   <= sub_c;
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                a_q    <= {s_c, a_q[WIDTH-1:1]};
                b_q    <= {1'b0, b_q[WIDTH-1:1]};
                c_q    <= cout_c;
                sbit_q <= s_c;
                sbv_q  <= 1'b1;
                if (last_c) begin
                    sum_q <= {s_c, a_q[WIDTH-1:1]};
                    co_q  <= cout_c;
                    ovf_q <= c_q ^ cout_c;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sum           = sum_q;
    assign bus.carry_out     = co_q;
    assign bus.ovf           = ovf_q;
    assign bus.sum_bit       = sbit_q;
    assign bus.sum_bit_valid = sbv_q;
endmodule
